posit_norm_arbiter: RTL

- Shares one quire normalizer (accumulator → sign / scale factor / 1.f mantissa) among NREQ MAC lanes.
- Round-robin arbitration; at most one accumulator issued per cycle.
- Tracks the lane ID of every in-flight operation in a tag FIFO and tags each normalizer result with its originating lane.
- Sequences flushes: drains in-flight work, then pulses the normalizer clear (vld_d==0 path).

---
 rtl/posit_norm_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/posit_norm_arbiter.sv
// rtl/posit_norm_arbiter.sv - round-robin sharing of one quire normalizer among MAC lanes, with lane tagging and flush sequencing (optional perf counters: POSIT_NORM_ARB_PERF_EN)
module posit_norm_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH_A = 40,
    parameter int DEPTH   = 4,
    parameter int WID     = $clog2(NREQ)
) (
    input  logic                    clk_i,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_vld_i,
    input  logic [NREQ*WIDTH_A-1:0] req_acc_i,
    output logic [NREQ-1:0]         req_rdy_o,
    input  logic                    flush_i,
    output logic                    norm_vld_o,
    output logic [WIDTH_A-1:0]      norm_acc_o,
    output logic                    norm_clr_o,
    input  logic                    res_vld_i,
    output logic                    out_vld_o,
    output logic [WID-1:0]          out_id_o,
    output logic                    busy_o,
`ifdef POSIT_NORM_ARB_PERF_EN
    output logic [15:0]             issue_cnt_o,
    output logic [15:0]             stall_cnt_o,
`endif
    output logic                    err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WID-1:0]  ptr;
    logic [WID-1:0]  grant;
    logic            found;
    logic            can_issue;
    logic            accept;
    logic            pop;
    logic [CW-1:0]   count, count_nxt;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [WID-1:0]  tags [DEPTH];

    assign can_issue = (state == RUN) && (count < CW'(DEPTH));
    assign accept    = found && can_issue;
    assign pop       = res_vld_i && (count != '0);
    assign out_vld_o = pop;
    assign out_id_o  = (count != '0) ? tags[rd_ptr] : '0;
    assign busy_o    = (count != '0) || (state != RUN);

    // Round-robin search: first valid lane starting at ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_vld_i[idx]) begin
                found = 1'b1;
                grant = WID'(idx);
            end
        end
    end

    // One-hot grant, only while issue is permitted.
    always_comb begin
        req_rdy_o = '0;
        if (accept) begin
            req_rdy_o[grant] = 1'b1;
        end
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_nxt = count;
        case ({accept, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Flush sequencer next-state and clear strobe.
    always_comb begin
        state_nxt  = state;
        norm_clr_o = 1'b0;
        case (state)
            RUN:     if (flush_i) state_nxt = DRAIN;
            DRAIN:   if (count_nxt == '0) state_nxt = CLEAR;
            CLEAR: begin
                norm_clr_o = 1'b1;
                state_nxt  = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // State, pointers, occupancy, issue register and sticky error.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state      <= RUN;
            ptr        <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            norm_vld_o <= 1'b0;
            norm_acc_o <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            norm_vld_o <= accept;
            if (accept) begin
                norm_acc_o <= req_acc_i[int'(grant)*WIDTH_A +: WIDTH_A];
                wr_ptr     <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (state == CLEAR) begin
                ptr <= '0;
            end else if (accept) begin
                ptr <= (grant == WID'(NREQ - 1)) ? '0 : grant + WID'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (res_vld_i && (count == '0)) begin
                err_o <= 1'b1;
            end
        end
    end

    // Tag storage; contents are meaningless while count is zero.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tags[wr_ptr] <= grant;
        end
    end

`ifdef POSIT_NORM_ARB_PERF_EN
    // Saturating issue and stall counters, cleared at the end of a flush.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            issue_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else if (state == CLEAR) begin
            issue_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (accept && (issue_cnt_o != 16'hFFFF)) begin
                issue_cnt_o <= issue_cnt_o + 16'd1;
            end
            if ((|req_vld_i) && !can_issue && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
